// File: rtl/mouse_pkg.sv
// Shared types and helpers for the mouse event post-processor.
package mouse_pkg;

  // Width of clamped screen coordinates (covers 0..2047).
  localparam int COORD_W = 11;

  // Per-button gesture state.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    DRAG     = 3'd2,
    WAIT2    = 3'd3,
    PRESSED2 = 3'd4
  } btn_state_t;

  // Clock cycles per millisecond, never less than one.
  function automatic int ms_tick_div(input int clk_hz);
    int div;
    div = clk_hz / 1000;
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/mouse_btn_fsm.sv
// One button's gesture tracker: sampled-edge detection, press/click/double/drag
// classification and the double-click window timer.
module mouse_btn_fsm
  import mouse_pkg::*;
#(
  parameter int DBLCLK_MS = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic level,
  input  logic drag_hit,
  input  logic ms_tick,
  output logic rise,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic dbl_pulse,
  output logic drag_level,
  output logic drag_end_pulse
);

  localparam int TMR_W = (DBLCLK_MS < 1) ? 1 : $clog2(DBLCLK_MS + 1);

  btn_state_t       state_reg;
  logic             level_prev_reg;
  logic [TMR_W-1:0] timer_reg;
  logic             fall;

  // Edges are taken between consecutive sampled levels, not between clock cycles.
  assign rise = sample & level & ~level_prev_reg;
  assign fall = sample & ~level & level_prev_reg;

  // Gesture state machine; edges take priority over the drag test, and a press
  // arriving on the same tick that closes the window still counts as a double.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      level_prev_reg <= 1'b0;
      timer_reg      <= '0;
      press_pulse    <= 1'b0;
      release_pulse  <= 1'b0;
      click_pulse    <= 1'b0;
      dbl_pulse      <= 1'b0;
      drag_level     <= 1'b0;
      drag_end_pulse <= 1'b0;
    end else begin
      press_pulse    <= 1'b0;
      release_pulse  <= 1'b0;
      click_pulse    <= 1'b0;
      dbl_pulse      <= 1'b0;
      drag_end_pulse <= 1'b0;
      if (sample) begin
        level_prev_reg <= level;
      end
      case (state_reg)
        IDLE: begin
          if (rise) begin
            state_reg   <= PRESSED;
            press_pulse <= 1'b1;
          end
        end
        PRESSED: begin
          if (fall) begin
            state_reg     <= WAIT2;
            release_pulse <= 1'b1;
            click_pulse   <= 1'b1;
            timer_reg     <= TMR_W'(DBLCLK_MS);
          end else if (sample && drag_hit) begin
            state_reg  <= DRAG;
            drag_level <= 1'b1;
          end
        end
        DRAG: begin
          if (fall) begin
            state_reg      <= IDLE;
            release_pulse  <= 1'b1;
            drag_end_pulse <= 1'b1;
            drag_level     <= 1'b0;
          end
        end
        WAIT2: begin
          if (rise) begin
            state_reg   <= PRESSED2;
            press_pulse <= 1'b1;
          end else if (ms_tick) begin
            if (timer_reg <= TMR_W'(1)) begin
              state_reg <= IDLE;
              timer_reg <= '0;
            end else begin
              timer_reg <= timer_reg - TMR_W'(1);
            end
          end
        end
        PRESSED2: begin
          if (fall) begin
            state_reg     <= IDLE;
            release_pulse <= 1'b1;
            dbl_pulse     <= 1'b1;
          end else if (sample && drag_hit) begin
            state_reg  <= DRAG;
            drag_level <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/mouse_event_ctrl.sv
// Mouse post-processor: clamps MouseCtl position to the screen, derives board
// cells, latches the press point, runs the ms prescaler and one gesture FSM
// per button.
module mouse_event_ctrl
  import mouse_pkg::*;
#(
  parameter int SCREEN_W    = 1280,
  parameter int SCREEN_H    = 1024,
  parameter int CELL_SHIFT  = 6,
  parameter int NUM_BTN     = 2,
  parameter int CLK_HZ      = 108000000,
  parameter int DBLCLK_MS   = 300,
  parameter int DRAG_THRESH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [11:0]                 raw_x,
  input  logic [11:0]                 raw_y,
  input  logic [NUM_BTN-1:0]          raw_btn,
  input  logic                        new_event,
  output logic [COORD_W-1:0]          x_pos,
  output logic [COORD_W-1:0]          y_pos,
  output logic [COORD_W-CELL_SHIFT-1:0] cell_col,
  output logic [COORD_W-CELL_SHIFT-1:0] cell_row,
  output logic [COORD_W-1:0]          press_x,
  output logic [COORD_W-1:0]          press_y,
  output logic [NUM_BTN-1:0]          btn_press,
  output logic [NUM_BTN-1:0]          btn_release,
  output logic [NUM_BTN-1:0]          btn_click,
  output logic [NUM_BTN-1:0]          btn_dbl,
  output logic [NUM_BTN-1:0]          btn_drag,
  output logic [NUM_BTN-1:0]          drag_end
);

  localparam int TICK_DIV = ms_tick_div(CLK_HZ);
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;
  logic [COORD_W-1:0] x_pos_reg;
  logic [COORD_W-1:0] y_pos_reg;
  logic [COORD_W-1:0] press_x_reg;
  logic [COORD_W-1:0] press_y_reg;
  logic [PRE_W-1:0]   pre_cnt_reg;
  logic               ms_tick;
  logic               drag_hit;
  logic               any_rise;
  logic [NUM_BTN-1:0] rise_vec;
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic [11:0]        dx_abs;
  logic [11:0]        dy_abs;

  // Clamp the raw position to the visible area.
  always_comb begin
    x_next = (raw_x > 12'(SCREEN_W - 1)) ? COORD_W'(SCREEN_W - 1) : raw_x[COORD_W-1:0];
    y_next = (raw_y > 12'(SCREEN_H - 1)) ? COORD_W'(SCREEN_H - 1) : raw_y[COORD_W-1:0];
  end

  // Drag test: new position against the latched press point, signed 12-bit distance.
  always_comb begin
    dx       = $signed({1'b0, x_next}) - $signed({1'b0, press_x_reg});
    dy       = $signed({1'b0, y_next}) - $signed({1'b0, press_y_reg});
    dx_abs   = dx[11] ? $unsigned(-dx) : $unsigned(dx);
    dy_abs   = dy[11] ? $unsigned(-dy) : $unsigned(dy);
    drag_hit = (dx_abs > 12'(DRAG_THRESH)) || (dy_abs > 12'(DRAG_THRESH));
  end

  assign ms_tick  = (pre_cnt_reg == PRE_W'(TICK_DIV - 1));
  assign any_rise = |rise_vec;

  // Free-running millisecond prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_reg <= '0;
    end else if (ms_tick) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
    end
  end

  // Position registers update on each event; the press point follows any rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_pos_reg   <= '0;
      y_pos_reg   <= '0;
      press_x_reg <= '0;
      press_y_reg <= '0;
    end else if (new_event) begin
      x_pos_reg <= x_next;
      y_pos_reg <= y_next;
      if (any_rise) begin
        press_x_reg <= x_next;
        press_y_reg <= y_next;
      end
    end
  end

  assign x_pos    = x_pos_reg;
  assign y_pos    = y_pos_reg;
  assign cell_col = x_pos_reg[COORD_W-1:CELL_SHIFT];
  assign cell_row = y_pos_reg[COORD_W-1:CELL_SHIFT];
  assign press_x  = press_x_reg;
  assign press_y  = press_y_reg;

  // One independent gesture tracker per button, sharing the drag test and tick.
  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      mouse_btn_fsm #(
        .DBLCLK_MS(DBLCLK_MS)
      ) u_btn_fsm (
        .clk           (clk),
        .rst           (rst),
        .sample        (new_event),
        .level         (raw_btn[gi]),
        .drag_hit      (drag_hit),
        .ms_tick       (ms_tick),
        .rise          (rise_vec[gi]),
        .press_pulse   (btn_press[gi]),
        .release_pulse (btn_release[gi]),
        .click_pulse   (btn_click[gi]),
        .dbl_pulse     (btn_dbl[gi]),
        .drag_level    (btn_drag[gi]),
        .drag_end_pulse(drag_end[gi])
      );
    end
  endgenerate

endmodule

// File: doc/mouse_event_ctrl.md
Name: mouse_event_ctrl

Overview:
Parametrised post-processor between MouseCtl and game logic on the 108 MHz pixel clock. Samples raw PS/2 mouse position and buttons on each new_event and produces clamped screen coordinates and board-cell indices. For each of NUM_BTN buttons it also generates per-event pulses: press, release, click, double-click, drag start and drag end. It replaces ad-hoc edge detection on MOUSE_LEFT/MOUSE_RIGHT in the top level.

Parameters:
SCREEN_W, 1280, visible width in pixels; x is clamped to SCREEN_W-1.
SCREEN_H, 1024, visible height in pixels; y is clamped to SCREEN_H-1.
CELL_SHIFT, 6, log2 of cell size in pixels (64x64 cells); cell = coord >> CELL_SHIFT.
NUM_BTN, 2, number of buttons tracked (bit0 left, bit1 right, bit2 middle).
CLK_HZ, 108000000, clock frequency; sets the 1 ms tick prescaler.
DBLCLK_MS, 300, double-click window in ms, measured from the first release.
DRAG_THRESH, 8, pixel distance from the press point that turns a press into a drag.

Ports:
clk  input  1  system/pixel clock
rst  input  1  asynchronous, active-low reset
raw_x  input  12  MouseCtl xpos
raw_y  input  12  MouseCtl ypos
raw_btn  input  NUM_BTN  MouseCtl button levels
new_event  input  1  one-cycle strobe; inputs are valid in this cycle
x_pos  output  11  clamped x
y_pos  output  11  clamped y
cell_col  output  11-CELL_SHIFT  x_pos >> CELL_SHIFT
cell_row  output  11-CELL_SHIFT  y_pos >> CELL_SHIFT
press_x  output  11  x_pos latched at the most recent press
press_y  output  11  y_pos latched at the most recent press
btn_press  output  NUM_BTN  one-cycle press pulse
btn_release  output  NUM_BTN  one-cycle release pulse
btn_click  output  NUM_BTN  one-cycle single click (press+release, no drag)
btn_dbl  output  NUM_BTN  one-cycle double-click
btn_drag  output  NUM_BTN  level; high while dragging
drag_end  output  NUM_BTN  one-cycle pulse when a drag is released

Behaviour:
- Reset (rst=0, async): all outputs 0, all button FSMs IDLE, timers and prescaler 0. Reset asserted mid-drag or mid-window drops the gesture with no pulses.
- Inputs are sampled only when new_event=1. All other cycles hold position and state, apart from timer ticks.
- Latency: every output is registered and updates in cycle N+1 after new_event in cycle N.
- Clamp: x_pos = min(raw_x, SCREEN_W-1); y_pos = min(raw_y, SCREEN_H-1). Same for cells.
- Button edge: compares sampled raw_btn[i] against the previous sampled level. It does not compare against the previous clock cycle.
- Drag test: |x_pos - press_x| > DRAG_THRESH OR |y_pos - press_y| > DRAG_THRESH. Uses the new position and signed 12-bit difference.
- Prescaler: a counter to CLK_HZ/1000-1 emits ms_tick.
- Window timer: per button, loaded with DBLCLK_MS on first release, decremented on ms_tick.
- Per-button FSM states:
  - IDLE: rise → PRESSED, pulse press.
  - PRESSED: fall → WAIT2, pulse release+click, load timer. Drag test true → DRAG, btn_drag=1.
  - DRAG: fall → IDLE, pulse release+drag_end, btn_drag=0.
  - WAIT2: rise → PRESSED2, pulse press. Timer reaching 0 → IDLE.
  - PRESSED2: fall → IDLE, pulse release+dbl; no click pulse. Drag test true → DRAG.
- Priority within one event: a button edge beats the drag test. A release with movement in the same event counts as a click/dbl, not a drag.
- Timer reaching 0 in the same cycle as a rise in WAIT2: the press wins and the gesture counts as a double.
- press_x/press_y latch on any rise. With simultaneous rises, every button latches the same sampled point.
- Buttons are independent. Simultaneous edges on several buttons each produce their own pulses in the same cycle.
- raw_btn width beyond NUM_BTN is not present; unused MouseCtl buttons are tied off at instantiation.

Decomposition:
- Package mouse_pkg holds:
  - btn FSM state enum (IDLE, PRESSED, DRAG, WAIT2, PRESSED2, 3 bits).
  - Coordinate width constant COORD_W=11.
  - ms-tick divisor function.
- Sub-module mouse_btn_fsm holds one button's FSM, edge detect and window timer. It is instantiated NUM_BTN times via generate.
- The top level owns clamp, cell shift, press-point latch, drag comparator and prescaler. The drag-test result is shared to all FSMs.

Test Plan:
Bench params: CLK_HZ=10000 (tick every 10 cycles), DBLCLK_MS=5, DRAG_THRESH=8, CELL_SHIFT=6.
- Reset, then new_event with raw=(2000,1500) → x_pos=1279, y_pos=1023, cell=(19,15) one cycle later; all pulses 0.
- Left press at (100,100), release at (104,103) → btn_press[0] then btn_release[0] and btn_click[0] one-cycle; btn_drag stays 0.
- Click, then re-press within 3 ms and release → second release gives btn_dbl[0]=1, btn_click[0]=0. Repeat with re-press after 6 ms → two btn_click[0] pulses, no btn_dbl.
- Right press at (200,200), move to (209,200) → btn_drag[1]=1 from cycle N+1; release → drag_end[1] pulse, btn_drag[1]=0, no click.
- Left and right rise on the same event at (300,400) → both btn_press bits set in the same cycle; press_x=300, press_y=400.
- Assert rst during DRAG and during WAIT2 → outputs 0 immediately (async). After release of rst, the next rise gives a plain press and the next release a click, not a double.
